fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter and the instruction
// register, and runs one outstanding memory read at a time with a bounded
// wait for the memory acknowledge.
module fetch_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PCReset,
  input  logic        PCWrite,
  input  logic        PCIncrement,
  input  logic [15:0] PCTarget,
  input  logic        IRWrite,
  input  logic        IRReset,
  input  logic [15:0] MemData,
  input  logic        MemAck,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  output logic [15:0] INS,
  output logic [15:0] PC,
  output logic        InsValid,
  output logic        Busy,
  output logic        FetchErr
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // The wait counter gives up on the cycle where it has already seen
  // TIMEOUT-1 ack-less cycles, so the request stays up for TIMEOUT cycles.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        start_fetch;
  logic        take_ack;
  logic        time_out;

  // Next-state decode; IRReset dominates everything the fetch FSM could do.
  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    take_ack    = 1'b0;
    time_out    = 1'b0;
    if (IRReset) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (IRWrite) begin
            start_fetch = 1'b1;
            next_state  = FETCH;
          end
        end
        FETCH: begin
          if (MemAck) begin
            take_ack   = 1'b1;
            next_state = IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            time_out   = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Program counter with PCReset > PCWrite > PCIncrement, independent of fetches.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC <= 16'h0000;
    end else if (PCReset) begin
      PC <= 16'h0000;
    end else if (PCWrite) begin
      PC <= PCTarget;
    end else if (PCIncrement) begin
      PC <= PC + 16'd1;
    end
  end

  // Fetch datapath: address latch, instruction register, status flags, wait counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      MemAddr  <= 16'h0000;
      INS      <= 16'h0000;
      InsValid <= 1'b0;
      FetchErr <= 1'b0;
      wait_cnt <= 8'd0;
    end else if (IRReset) begin
      INS      <= 16'h0000;
      InsValid <= 1'b0;
      FetchErr <= 1'b0;
      wait_cnt <= 8'd0;
    end else if (start_fetch) begin
      MemAddr  <= PC;
      InsValid <= 1'b0;
      FetchErr <= 1'b0;
      wait_cnt <= 8'd0;
    end else if (take_ack) begin
      INS      <= MemData;
      InsValid <= 1'b1;
      wait_cnt <= 8'd0;
    end else if (time_out) begin
      FetchErr <= 1'b1;
      wait_cnt <= 8'd0;
    end else if (state == FETCH) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // The request is the FETCH state bit itself, so it comes straight off a flop.
  assign MemReq = (state == FETCH);
  assign Busy   = MemReq;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, every cycle compared against a cycle-level reference model.
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clock;
  logic        reset;
  logic        pc_reset;
  logic        pc_write;
  logic        pc_increment;
  logic [15:0] pc_target;
  logic        ir_write;
  logic        ir_reset;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] ins;
  logic [15:0] pc;
  logic        ins_valid;
  logic        busy;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_ins;
  logic [15:0] m_addr;
  logic        m_valid;
  logic        m_busy;
  logic        m_err;
  int          m_waited;

  fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .Clock(clock),
    .Reset(reset),
    .PCReset(pc_reset),
    .PCWrite(pc_write),
    .PCIncrement(pc_increment),
    .PCTarget(pc_target),
    .IRWrite(ir_write),
    .IRReset(ir_reset),
    .MemData(mem_data),
    .MemAck(mem_ack),
    .MemReq(mem_req),
    .MemAddr(mem_addr),
    .INS(ins),
    .PC(pc),
    .InsValid(ins_valid),
    .Busy(busy),
    .FetchErr(fetch_err)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    reset        = 1'b0;
    pc_reset     = 1'b0;
    pc_write     = 1'b0;
    pc_increment = 1'b0;
    pc_target    = 16'h0000;
    ir_write     = 1'b0;
    ir_reset     = 1'b0;
    mem_data     = 16'h0000;
    mem_ack      = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic modelStep();
    logic [15:0] old_pc;
    old_pc = m_pc;
    if (reset) begin
      m_pc = 0; m_ins = 0; m_addr = 0; m_valid = 0; m_busy = 0; m_err = 0; m_waited = 0;
    end else begin
      if (pc_reset)          m_pc = 16'h0000;
      else if (pc_write)     m_pc = pc_target;
      else if (pc_increment) m_pc = 16'((int'(m_pc) + 1) % 65536);
      if (ir_reset) begin
        m_ins = 0; m_valid = 0; m_err = 0; m_busy = 0; m_waited = 0;
      end else if (!m_busy) begin
        if (ir_write) begin
          m_busy = 1; m_addr = old_pc; m_valid = 0; m_err = 0; m_waited = 0;
        end
      end else if (mem_ack) begin
        m_ins = mem_data; m_valid = 1; m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited >= TIMEOUT) begin
          m_busy = 0; m_err = 1;
        end
      end
    end
  endtask

  // One clock: update the model, let the edge happen, compare all outputs.
  task automatic applyStimulus();
    modelStep();
    @(posedge clock);
    #1;
    checkOutput("pc",        32'(pc),        32'(m_pc));
    checkOutput("ins",       32'(ins),       32'(m_ins));
    checkOutput("ins_valid", 32'(ins_valid), 32'(m_valid));
    checkOutput("mem_req",   32'(mem_req),   32'(m_busy));
    checkOutput("busy",      32'(busy),      32'(m_busy));
    checkOutput("fetch_err", 32'(fetch_err), 32'(m_err));
    if (m_busy) checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
    else if (reset) checkOutput("mem_addr_rst", 32'(mem_addr), 32'h0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      clearInputs();
      applyStimulus();
    end
  endtask

  initial begin
    int req_high;
    m_pc = 0; m_ins = 0; m_addr = 0; m_valid = 0; m_busy = 0; m_err = 0; m_waited = 0;
    clearInputs();
    @(negedge clock);

    // Reset state
    reset = 1'b1;
    applyStimulus();
    checkOutput("reset_addr", 32'(mem_addr), 32'h0);

    // Basic fetch with an ack after three waiting cycles
    clearInputs(); pc_write = 1'b1; pc_target = 16'h0040; applyStimulus();
    clearInputs(); ir_write = 1'b1; applyStimulus();
    idleCycles(3);
    clearInputs(); mem_ack = 1'b1; mem_data = 16'hA5C3; applyStimulus();
    checkOutput("basic_addr",  32'(mem_addr),  32'h0040);
    checkOutput("basic_ins",   32'(ins),       32'hA5C3);
    checkOutput("basic_valid", 32'(ins_valid), 32'h1);
    checkOutput("basic_req",   32'(mem_req),   32'h0);

    // IDLE ignores MemAck
    clearInputs(); mem_ack = 1'b1; mem_data = 16'h5555; applyStimulus();
    checkOutput("idle_ack_ins", 32'(ins), 32'hA5C3);

    // PC wrap and command priority
    clearInputs(); pc_write = 1'b1; pc_target = 16'hFFFF; applyStimulus();
    clearInputs(); pc_increment = 1'b1; applyStimulus();
    checkOutput("pc_wrap", 32'(pc), 32'h0);
    clearInputs(); pc_write = 1'b1; pc_target = 16'h0005; applyStimulus();
    clearInputs(); pc_reset = 1'b1; pc_write = 1'b1; pc_increment = 1'b1; pc_target = 16'h1111; applyStimulus();
    checkOutput("pc_prio", 32'(pc), 32'h0);
    clearInputs(); pc_write = 1'b1; pc_increment = 1'b1; pc_target = 16'h2222; applyStimulus();
    checkOutput("pc_write_over_inc", 32'(pc), 32'h2222);

    // Timeout: request held exactly TIMEOUT cycles
    clearInputs(); ir_write = 1'b1; applyStimulus();
    req_high = mem_req ? 1 : 0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      clearInputs(); ir_write = 1'b1; applyStimulus();
      if (mem_req) req_high++;
      else break;
    end
    checkOutput("timeout_len",   32'(req_high),  32'(TIMEOUT));
    checkOutput("timeout_err",   32'(fetch_err), 32'h1);
    checkOutput("timeout_valid", 32'(ins_valid), 32'h0);
    checkOutput("timeout_ins",   32'(ins),       32'hA5C3);
    idleCycles(2);
    checkOutput("err_sticky", 32'(fetch_err), 32'h1);

    // PC changes during FETCH leave MemAddr alone
    clearInputs(); pc_write = 1'b1; pc_target = 16'h0010; applyStimulus();
    clearInputs(); ir_write = 1'b1; applyStimulus();
    checkOutput("stable_err_clr", 32'(fetch_err), 32'h0);
    clearInputs(); pc_increment = 1'b1; applyStimulus();
    checkOutput("stable_addr1", 32'(mem_addr), 32'h0010);
    clearInputs(); pc_increment = 1'b1; applyStimulus();
    checkOutput("stable_addr2", 32'(mem_addr), 32'h0010);
    clearInputs(); mem_ack = 1'b1; mem_data = 16'hBEEF; applyStimulus();
    checkOutput("stable_addr3", 32'(mem_addr), 32'h0010);
    checkOutput("stable_pc",    32'(pc),       32'h0012);

    // IRReset beats a simultaneous MemAck, then a clean fetch follows
    clearInputs(); ir_write = 1'b1; applyStimulus();
    clearInputs(); ir_reset = 1'b1; mem_ack = 1'b1; mem_data = 16'h7777; applyStimulus();
    checkOutput("irrst_ins",   32'(ins),       32'h0);
    checkOutput("irrst_valid", 32'(ins_valid), 32'h0);
    checkOutput("irrst_req",   32'(mem_req),   32'h0);
    clearInputs(); ir_write = 1'b1; applyStimulus();
    checkOutput("refetch_req", 32'(mem_req), 32'h1);
    clearInputs(); mem_ack = 1'b1; mem_data = 16'h0F0F; applyStimulus();
    checkOutput("refetch_ins", 32'(ins), 32'h0F0F);

    // Reset mid-FETCH; a late ack is ignored
    clearInputs(); ir_write = 1'b1; applyStimulus();
    clearInputs(); reset = 1'b1; mem_ack = 1'b1; mem_data = 16'h9999; applyStimulus();
    clearInputs(); mem_ack = 1'b1; mem_data = 16'h1234; applyStimulus();
    applyStimulus();
    checkOutput("rst_fetch_ins",   32'(ins),       32'h0);
    checkOutput("rst_fetch_valid", 32'(ins_valid), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      clearInputs();
      reset        = ($urandom_range(0, 99) < 2);
      pc_reset     = ($urandom_range(0, 99) < 5);
      pc_write     = ($urandom_range(0, 99) < 10);
      pc_increment = ($urandom_range(0, 99) < 30);
      pc_target    = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      ir_write     = ($urandom_range(0, 99) < 30);
      ir_reset     = ($urandom_range(0, 99) < 3);
      mem_ack      = ($urandom_range(0, 99) < 12);
      mem_data     = 16'($urandom);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
